// File: rtl/mulmod_pkg.sv
// Shared types and constants for the mulmod_pipe modular arithmetic unit.
package mulmod_pkg;

   typedef enum logic [1:0] {
      OP_MULMOD = 2'b00,
      OP_ADDMOD = 2'b01,
      OP_SUBMOD = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   localparam int unsigned LAT = 5;

endpackage

// File: rtl/barrett_reduce_pipe.sv
// Stages S2..S4 of mulmod_pipe: Barrett quotient estimate, remainder, final
// conditional subtractions. Every register advances only when en_i is high.
module barrett_reduce_pipe #(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  valid_i,
   input  logic [2*DATA_W-1:0]   x_i,
   input  logic [TAG_W-1:0]      tag_i,
   input  logic [DATA_W-1:0]     q_i,
   input  logic [DATA_W:0]       mu_i,
   output logic                  valid_o,
   output logic [DATA_W-1:0]     data_o,
   output logic [TAG_W-1:0]      tag_o,
   output logic                  busy_o
);
   localparam int K = DATA_W;

   logic              s2_valid_q;
   logic [K+1:0]      s2_x_q;
   logic [K:0]        s2_q3_q;
   logic [TAG_W-1:0]  s2_tag_q;
   logic              s3_valid_q;
   logic [K+1:0]      s3_r_q;
   logic [TAG_W-1:0]  s3_tag_q;
   logic              s4_valid_q;
   logic [K-1:0]      s4_data_q;
   logic [TAG_W-1:0]  s4_tag_q;

   logic [2*K+1:0]    prod_xmu;
   logic [K:0]        q3_d;
   logic [2*K:0]      prod_q3q;
   logic [K+1:0]      r_d;
   logic [K+1:0]      q_ext;
   logic [K+1:0]      r1;
   logic [K+1:0]      r2;

   // x >> (K-1) fits in K+1 bits because x < 2^(2K).
   assign prod_xmu = {{(K+1){1'b0}}, x_i[2*K-1:K-1]} * {{(K+1){1'b0}}, mu_i};
   assign q3_d     = prod_xmu[2*K+1:K+1];

   // r < 3q < 2^(K+2), so only the low K+2 bits of x - q3*q are needed.
   assign prod_q3q = {{K{1'b0}}, s2_q3_q} * {{(K+1){1'b0}}, q_i};
   assign r_d      = s2_x_q - prod_q3q[K+1:0];

   assign q_ext = {2'b00, q_i};
   assign r1    = (s3_r_q >= q_ext) ? s3_r_q - q_ext : s3_r_q;
   assign r2    = (r1 >= q_ext) ? r1 - q_ext : r1;

   // NOTE: clocked state uses non-blocking assignments so every stage samples
   // the pre-edge value of its predecessor; blocking here would collapse stages.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid_q <= 1'b0;
         s2_x_q     <= '0;
         s2_q3_q    <= '0;
         s2_tag_q   <= '0;
         s3_valid_q <= 1'b0;
         s3_r_q     <= '0;
         s3_tag_q   <= '0;
         s4_valid_q <= 1'b0;
         s4_data_q  <= '0;
         s4_tag_q   <= '0;
      end else if (en_i) begin
         s2_valid_q <= valid_i;
         s2_x_q     <= x_i[K+1:0];
         s2_q3_q    <= q3_d;
         s2_tag_q   <= tag_i;
         s3_valid_q <= s2_valid_q;
         s3_r_q     <= r_d;
         s3_tag_q   <= s2_tag_q;
         s4_valid_q <= s3_valid_q;
         s4_data_q  <= r2[K-1:0];
         s4_tag_q   <= s3_tag_q;
      end
   end

   assign valid_o = s4_valid_q;
   assign data_o  = s4_data_q;
   assign tag_o   = s4_tag_q;
   assign busy_o  = s2_valid_q | s3_valid_q | s4_valid_q;

endmodule

// File: rtl/mulmod_pipe.sv
// Pipelined a*b / a+b / a-b mod q with runtime-loadable modulus and Barrett
// constant, valid/ready on both sides and a pass-through tag.
module mulmod_pipe #(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 8,
   parameter int LAT    = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_load,
   input  logic [DATA_W-1:0]   cfg_modulus,
   input  logic [DATA_W:0]     cfg_mu,
   output logic                cfg_err,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_op,
   input  logic [DATA_W-1:0]   in_a,
   input  logic [DATA_W-1:0]   in_b,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [TAG_W-1:0]    out_tag,
   output logic                busy
);
   import mulmod_pkg::*;

   if (LAT != mulmod_pkg::LAT) begin : g_lat_check
      $error("mulmod_pipe: LAT must be 5");
   end

   typedef struct packed {
      logic                 valid;
      logic [2*DATA_W-1:0]  x;
      logic [TAG_W-1:0]     tag;
   } stage_t;

   logic [DATA_W-1:0]  mod_q;
   logic [DATA_W:0]    mu_q;
   logic               configured_q;
   logic               cfg_err_q;

   logic               s0_valid_q;
   logic [DATA_W-1:0]  s0_a_q;
   logic [DATA_W-1:0]  s0_b_q;
   op_e                s0_op_q;
   logic [TAG_W-1:0]   s0_tag_q;
   stage_t             s1_q;
   stage_t             s1_d;

   logic               en;
   logic               cfg_accept;
   logic               red_busy;
   logic [DATA_W:0]    sum_ab;
   logic [DATA_W:0]    diff_ab;

   assign en         = !out_valid || out_ready;
   assign in_ready   = en && !cfg_load && configured_q;
   // Changing q or mu under in-flight work would corrupt it, so loads need idle.
   assign cfg_accept = cfg_load && !busy && cfg_modulus[DATA_W-1];
   assign cfg_err    = cfg_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mod_q        <= '0;
         mu_q         <= '0;
         configured_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         cfg_err_q <= cfg_load && !cfg_accept;
         if (cfg_accept) begin
            mod_q        <= cfg_modulus;
            mu_q         <= cfg_mu;
            configured_q <= 1'b1;
         end
      end
   end

   assign sum_ab  = {1'b0, s0_a_q} + {1'b0, s0_b_q};
   assign diff_ab = {1'b0, s0_a_q} + {1'b0, mod_q} - {1'b0, s0_b_q};

   // NOTE: every field of s1_d gets a value before the case so no latch is inferred.
   always_comb begin
      s1_d.valid = s0_valid_q;
      s1_d.tag   = s0_tag_q;
      s1_d.x     = {{DATA_W{1'b0}}, s0_a_q} * {{DATA_W{1'b0}}, s0_b_q};
      case (s0_op_q)
         OP_ADDMOD: s1_d.x = {{(DATA_W-1){1'b0}}, sum_ab};
         OP_SUBMOD: s1_d.x = {{(DATA_W-1){1'b0}}, diff_ab};
         default:   ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_valid_q <= 1'b0;
         s0_a_q     <= '0;
         s0_b_q     <= '0;
         s0_op_q    <= OP_MULMOD;
         s0_tag_q   <= '0;
         s1_q       <= '0;
      end else if (en) begin
         s0_valid_q <= in_valid && in_ready;
         s0_a_q     <= in_a;
         s0_b_q     <= in_b;
         s0_op_q    <= op_e'(in_op);
         s0_tag_q   <= in_tag;
         s1_q       <= s1_d;
      end
   end

   barrett_reduce_pipe #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W)
   ) u_reduce (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en),
      .valid_i (s1_q.valid),
      .x_i     (s1_q.x),
      .tag_i   (s1_q.tag),
      .q_i     (mod_q),
      .mu_i    (mu_q),
      .valid_o (out_valid),
      .data_o  (out_data),
      .tag_o   (out_tag),
      .busy_o  (red_busy)
   );

   assign busy = s0_valid_q | s1_q.valid | red_busy;

endmodule
